// File: rtl/piso_ser.sv
// piso_ser: parallel-in/serial-out shifter, MSB first, valid/ready load handshake.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.  Rev 1.0
`default_nettype none

module piso_ser #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] c_LAST = CW'(N - 1);
`ifndef PISO_PARITY_EN
  localparam logic [CW-1:0] c_PENULT = CW'(N - 2);
`endif

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
  logic par_q;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t         state_q;
  logic [N-1:0]   shreg_q;
  logic [CW-1:0]  cnt_q;
  logic           vld_q;
  logic           done_q;

  assign load_ready = (state_q == IDLE);
  // The shift register MSB is the serial output; it is cleared whenever idle.
  assign sout       = shreg_q[N-1];
  assign sout_valid = vld_q;
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid && load_ready) begin
            state_q <= SHIFT;
            shreg_q <= a;
            cnt_q   <= '0;
            vld_q   <= 1'b1;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= ^a;
`endif
          end
        end
        SHIFT: begin
          if (cnt_q == c_LAST) begin
`ifdef PISO_PARITY_EN
            state_q <= PAR;
            shreg_q <= {par_q, {(N-1){1'b0}}};
            done_q  <= 1'b1;
`else
            state_q <= IDLE;
            shreg_q <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
`endif
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            shreg_q <= {shreg_q[N-2:0], 1'b0};
`ifdef PISO_PARITY_EN
            done_q  <= 1'b0;
`else
            // Flag the bit about to appear as the last data bit.
            done_q  <= (cnt_q == c_PENULT);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PAR: begin
          state_q <= IDLE;
          shreg_q <= '0;
          vld_q   <= 1'b0;
          done_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= IDLE;
          shreg_q <= '0;
          cnt_q   <= '0;
          vld_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_ser.sv
// tb_piso_ser: scoreboard bench for piso_ser (N=4); expected serial bits are
// queued by the stimulus and popped by a negedge monitor.
`default_nettype none

module tb_piso_ser;

  localparam int N = 4;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NB = 5;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NB = 4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] a = '0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         done;

  piso_ser #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;
  logic [1:0] exp_q[$];   // {sout, done}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Queue the first nbits serial beats of word w (data bits, then parity).
  task automatic push_word(input logic [N-1:0] w, input int nbits);
    for (int i = 0; i < N; i++)
      if (i < nbits) exp_q.push_back({w[N-1-i], (!PAR_EN && i == N-1)});
    if (PAR_EN && nbits == NB) exp_q.push_back({^w, 1'b1});
  endtask

  // Present w at a negedge, hold until accepted; returns 1ns after the accept edge.
  task automatic drive(input logic [N-1:0] w, input bit keep_valid);
    int guard = 0;
    @(negedge clk);
    a = w;
    load_valid = 1'b1;
    while (!load_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (!keep_valid) load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!load_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("idle_timeout", 32'd1, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'd1, 32'd0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check("sout_done", {30'd0, sout, done}, {30'd0, e});
        end
      end else begin
        check("idle_outputs", {30'd0, sout, done}, 32'd0);
      end
    end
  end

  initial begin
    // Reset for two edges, then idle outputs.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sout", {31'd0, sout}, 32'd0);
    check("rst_valid", {31'd0, sout_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd1);
    mon_en = 1'b1;

    // Plain word 1011, ready low for the whole stream, high afterwards.
    push_word(4'b1011, NB);
    drive(4'b1011, 1'b0);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      check("ready_busy", {31'd0, load_ready}, 32'd0);
    end
    @(negedge clk);
    check("ready_after", {31'd0, load_ready}, 32'd1);

    // A load attempt during the 2nd bit is ignored.
    push_word(4'b1011, NB);
    drive(4'b1011, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 4'b0110;
    load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
    wait_idle();

    // Word 0110 (parity 0 when enabled).
    push_word(4'b0110, NB);
    drive(4'b0110, 1'b0);
    wait_idle();

    // Reset while the 2nd bit of 1100 is on sout: stream aborted, no done.
    push_word(4'b1100, 2);
    drive(4'b1100, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_valid", {31'd0, sout_valid}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sout", {31'd0, sout}, 32'd0);
    check("abort_ready", {31'd0, load_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Back-to-back words with load_valid held: one idle cycle between streams.
    push_word(4'b1000, NB);
    push_word(4'b0001, NB);
    drive(4'b1000, 1'b1);
    a = 4'b0001;
    for (int i = 0; i < NB; i++) @(negedge clk);
    @(negedge clk);
    check("gap_valid", {31'd0, sout_valid}, 32'd0);
    check("gap_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    check("second_start", {31'd0, sout_valid}, 32'd1);
    load_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
